// File: rtl/pipe_ctrl_unit.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_unit
//   Pipelined main control for the RISC-V core. Decodes the opcode held in ID,
//   then carries the control word through the ID/EX, EX/MEM and MEM/WB stage
//   registers. Also detects load-use hazards, squashes younger stages on a
//   taken branch/jump and counts accepted illegal opcodes (saturating).
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   id_valid            ID holds a real instruction
//   id_opcode           instruction[6:0]
//   id_rs1/rs2/rd       register fields of the instruction in ID
//   flush               branch/jump taken in MEM; squash ID/EX and EX/MEM
//   hazard_stall        combinational; hold PC and IF/ID this cycle
//   ex_*                ID/EX register outputs
//   mem_*               EX/MEM register outputs
//   wb_*                MEM/WB register outputs
//   illegal_cnt         saturating count of accepted illegal opcodes
// -----------------------------------------------------------------------------
module pipe_ctrl_unit #(
   parameter int REG_ADDR_W = 5,
   parameter bit EXT_EN     = 1'b1,
   parameter int CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [6:0]            id_opcode,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  flush,
   output logic                  hazard_stall,
   output logic                  ex_valid,
   output logic                  ex_alu_src,
   output logic                  ex_jump_reg,
   output logic [1:0]            ex_alu_op,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  mem_valid,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  mem_branch,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  wb_valid,
   output logic                  wb_reg_write,
   output logic                  wb_mem_to_reg,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [CNT_W-1:0]      illegal_cnt
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_SD    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   typedef struct packed {
      logic       branch;
      logic       mem_read;
      logic       mem_to_reg;
      logic [1:0] alu_op;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic       jump_reg;
   } ctrl_t;

   // ---------------------------------------------------------------- decode
   ctrl_t                  dec;
   logic                   legal;
   logic                   uses_rs2;
   ctrl_t                  id_word;
   logic [REG_ADDR_W-1:0]  id_rd_store;

   // NOTE: every signal driven here gets a default before the case so that no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      dec      = '0;
      legal    = 1'b0;
      uses_rs2 = 1'b0;
      case (id_opcode)
         OP_R:   begin dec = '{1'b0,1'b0,1'b0,2'b10,1'b0,1'b0,1'b1,1'b0}; legal = 1'b1; uses_rs2 = 1'b1; end
         OP_LD:  begin dec = '{1'b0,1'b1,1'b1,2'b00,1'b0,1'b1,1'b1,1'b0}; legal = 1'b1; end
         OP_SD:  begin dec = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0}; legal = 1'b1; uses_rs2 = 1'b1; end
         OP_BEQ: begin dec = '{1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0}; legal = 1'b1; uses_rs2 = 1'b1; end
         OP_JAL: begin dec = '{1'b1,1'b0,1'b0,2'b11,1'b0,1'b1,1'b1,1'b0}; legal = 1'b1; end
         OP_IMM:  if (EXT_EN) begin dec = '{1'b0,1'b0,1'b0,2'b10,1'b0,1'b1,1'b1,1'b0}; legal = 1'b1; end
         OP_LUI:  if (EXT_EN) begin dec = '{1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,1'b0}; legal = 1'b1; end
         OP_JALR: if (EXT_EN) begin dec = '{1'b1,1'b0,1'b0,2'b11,1'b0,1'b1,1'b1,1'b1}; legal = 1'b1; end
         default: ;
      endcase

      // Gate with id_valid; a write to x0 is no write at all.
      id_word = id_valid ? dec : '0;
      if (id_rd == '0) id_word.reg_write = 1'b0;

      // Only instructions that write a register keep rd (sd/beq store 0), so
      // downstream forwarding never matches on a store/branch rd field.
      id_rd_store = (id_valid && dec.reg_write) ? id_rd : '0;
   end

   // ---------------------------------------------------------- stage regs
   ctrl_t                 idex_q;
   logic                  idex_valid_q;
   logic [REG_ADDR_W-1:0] idex_rd_q;

   logic                  exmem_reg_write_q;
   logic                  exmem_mem_to_reg_q;

   // Load in EX whose destination is read by the instruction in ID.
   logic haz;
   assign haz = id_valid & idex_valid_q & idex_q.mem_read & (idex_rd_q != '0) &
                ((idex_rd_q == id_rs1) | (uses_rs2 & (idex_rd_q == id_rs2)));

   assign hazard_stall = haz & ~flush;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // NOTE: state is updated with non-blocking assignments so every stage
   // samples the previous value of the stage before it on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_q             <= '0;
         idex_valid_q       <= 1'b0;
         idex_rd_q          <= '0;
         mem_valid          <= 1'b0;
         mem_read           <= 1'b0;
         mem_write          <= 1'b0;
         mem_branch         <= 1'b0;
         mem_rd             <= '0;
         exmem_reg_write_q  <= 1'b0;
         exmem_mem_to_reg_q <= 1'b0;
         wb_valid           <= 1'b0;
         wb_reg_write       <= 1'b0;
         wb_mem_to_reg      <= 1'b0;
         wb_rd              <= '0;
         illegal_cnt        <= '0;
      end else begin
         // ID/EX: flush and hazard both insert a bubble.
         if (flush || haz) begin
            idex_q       <= '0;
            idex_valid_q <= 1'b0;
            idex_rd_q    <= '0;
         end else begin
            idex_q       <= id_word;
            idex_valid_q <= id_valid;
            idex_rd_q    <= id_rd_store;
         end

         // EX/MEM: the instruction in EX is younger than the taken branch.
         if (flush) begin
            mem_valid          <= 1'b0;
            mem_read           <= 1'b0;
            mem_write          <= 1'b0;
            mem_branch         <= 1'b0;
            mem_rd             <= '0;
            exmem_reg_write_q  <= 1'b0;
            exmem_mem_to_reg_q <= 1'b0;
         end else begin
            mem_valid          <= idex_valid_q;
            mem_read           <= idex_q.mem_read;
            mem_write          <= idex_q.mem_write;
            mem_branch         <= idex_q.branch;
            mem_rd             <= idex_rd_q;
            exmem_reg_write_q  <= idex_q.reg_write;
            exmem_mem_to_reg_q <= idex_q.mem_to_reg;
         end

         // MEM/WB: the branch/jal sitting in MEM commits, so never squashed.
         wb_valid      <= mem_valid;
         wb_reg_write  <= exmem_reg_write_q;
         wb_mem_to_reg <= exmem_mem_to_reg_q;
         wb_rd         <= mem_rd;

         // Count only illegal opcodes that actually leave ID.
         if (id_valid && !legal && !haz && !flush && (illegal_cnt != '1))
            illegal_cnt <= illegal_cnt + CNT_ONE;
      end
   end

   assign ex_valid    = idex_valid_q;
   assign ex_alu_src  = idex_q.alu_src;
   assign ex_jump_reg = idex_q.jump_reg;
   assign ex_alu_op   = idex_q.alu_op;
   assign ex_rd       = idex_rd_q;

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the combinational main control decoder.
- Decodes the 7-bit opcode in ID and carries the control word through ID/EX, EX/MEM and MEM/WB stage registers, with valid bits and destination register.
- Adds load-use hazard detection (stall request), branch flush, optional extended opcodes and a saturating illegal-opcode counter.
- Sits between the IF/ID register and the datapath stage muxes of the RISC-V pipeline.

Parameters:
- REG_ADDR_W, 5, register address width.
- EXT_EN, 1, when 1 also decodes OP-IMM (0010011), LUI (0110111) and JALR (1100111); when 0 these are illegal.
- CNT_W, 8, illegal-opcode counter width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  7  instruction[6:0]
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  source/destination fields
- flush  in  1  branch/jump taken (from MEM); squash younger stages
- hazard_stall  out  1  combinational; hold PC and IF/ID
- ex_valid, ex_alu_src, ex_jump_reg  out  1  ID/EX register
- ex_alu_op  out  2  ID/EX register
- ex_rd  out  REG_ADDR_W  ID/EX register
- mem_valid, mem_read, mem_write, mem_branch  out  1  EX/MEM register
- mem_rd  out  REG_ADDR_W  EX/MEM register
- wb_valid, wb_reg_write, wb_mem_to_reg  out  1  MEM/WB register
- wb_rd  out  REG_ADDR_W  MEM/WB register
- illegal_cnt  out  CNT_W  saturating count of illegal opcodes accepted

Behaviour:
- Decode table, {branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write, jump_reg}:
  - R 0110011 = {0,0,0,10,0,0,1,0}
  - ld 0000011 = {0,1,1,00,0,1,1,0}
  - sd 0100011 = {0,0,0,00,1,1,0,0}
  - beq 1100011 = {1,0,0,01,0,0,0,0}
  - jal 1101111 = {1,0,0,11,0,1,1,0}
  - OP-IMM = {0,0,0,10,0,1,1,0}
  - LUI = {0,0,0,00,0,1,1,0}
  - JALR = {1,0,0,11,0,1,1,1}
  - Don't-care fields decode to 0; the word has no X.
- Illegal opcode (or extended opcode with EXT_EN=0): all-zero word.
- Decoded word is gated with id_valid: id_valid=0 gives an all-zero word.
- Stored reg_write and rd:
  - rd is stored as 0 for sd/beq.
  - reg_write is forced to 0 when id_rd==0.
- uses_rs2 = R, sd, beq.
- Hazard: haz = id_valid & ex_valid & mem_read_in_EX & (ex_rd!=0) & (ex_rd==id_rs1 | (uses_rs2 & ex_rd==id_rs2)). Here mem_read_in_EX is the ID/EX copy of mem_read, held internally.
- hazard_stall = haz & ~flush.
- Each clock edge, in priority order:
  - ID/EX: flush -> bubble (all 0, valid 0); else haz -> bubble; else the decoded word.
  - EX/MEM: flush -> bubble; else copy of ID/EX.
  - MEM/WB: always copy of EX/MEM. Flush never squashes MEM/WB, because the branch/jal in MEM commits.
- Latency: opcode in ID at cycle N appears on ex_* at N+1, mem_* at N+2, wb_* at N+3.
- A stall inserts exactly one bubble per cycle that haz holds. A load-use pair resolves after one bubble because the load then moves to MEM.
- illegal_cnt increments when id_valid & illegal & ~haz & ~flush, i.e. the instruction is actually accepted. It saturates at 2^CNT_W-1 and does not wrap.
- Reset: every stage register, every output register and illegal_cnt go to 0 immediately on rst_n low, including mid-stream. hazard_stall is 0 during reset because ex_valid=0. The first accepted instruction is the one in ID on the first edge after rst_n rises.

Test Plan:
- Stream R, ld, sd, beq, jal with rd=3, id_valid=1 -> each word appears on ex_/mem_/wb_ 1/2/3 cycles later exactly per the table; sd/beq show wb_rd=0, wb_reg_write=0.
- ld x5 then add x6,x5,x7 -> hazard_stall=1 for exactly one cycle; ex_valid=0 bubble; add reaches EX the following cycle with ex_alu_op=10.
- ld x0 followed by use of x0 -> hazard_stall stays 0; R-type with rd=0 -> wb_reg_write=0.
- beq in MEM with flush=1 while ID holds a hazarding use -> hazard_stall=0; next edge ex_valid=0 and mem_valid=0; wb_valid=1 carries the beq.
- EXT_EN=0, opcode 0010011 ×3 with one cycle stalled -> illegal_cnt=2; EXT_EN=1 gives JALR ex_jump_reg=1; CNT_W=2 with 5 illegals -> saturates at 3.
- Assert rst_n=0 mid-stream between edges -> all outputs 0 immediately; after release the pipeline refills from ID.
